// File: rtl/alu8_wb.sv
// Writeback/flag stage behind the 8-bit ALU: tags each result with carry/zero flags,
// buffers it in a small FIFO, and tracks a sticky divide-by-zero flag.
// Optional signed-overflow flag per entry is enabled with `define ALU8_WB_OVF_EN.
module alu8_wb #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    A,
    input  logic [7:0]    B,
    input  logic [3:0]    select,
    input  logic          cin,
    input  logic          bin,
    input  logic [7:0]    alu_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_c,
    output logic          out_z,
    output logic [3:0]    out_op,
    output logic [CW-1:0] count,
    output logic          div0_seen,
    input  logic          clr_div0
`ifdef ALU8_WB_OVF_EN
    ,
    output logic          out_v
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_ADC  = 4'b0100;
    localparam logic [3:0] OP_SBB  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_SHR  = 4'b1111;

    logic [7:0]    mem_data [DEPTH];
    logic          mem_c    [DEPTH];
    logic          mem_z    [DEPTH];
    logic [3:0]    mem_op   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    logic       push, pop, full, empty;
    logic       div0_hit, carry;
    logic [7:0] result;
    logic [8:0] sum9, sum_c9;
    logic [15:0] prod;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // Reset forces in_ready low so nothing can be accepted on the clearing edge.
    assign in_ready  = !rst && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign div0_hit = (select == OP_DIV) && (B == 8'h00);
    assign result   = div0_hit ? 8'hFF : alu_out;
    assign sum9     = {1'b0, A} + {1'b0, B};
    assign sum_c9   = sum9 + {8'b0, cin};
    assign prod     = {8'b0, A} * {8'b0, B};

    always_comb begin
        carry = 1'b0;
        case (select)
            OP_ADD:  carry = sum9[8];
            OP_SUB:  carry = (A < B);
            OP_MUL:  carry = (prod[15:8] != 8'h00);
            OP_DIV:  carry = (B == 8'h00);
            OP_ADC:  carry = sum_c9[8];
            OP_SBB:  carry = ({1'b0, A} < ({1'b0, B} + {8'b0, bin}));
            OP_SHL:  carry = A[7];
            OP_SHR:  carry = B[0];
            default: carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_c[i]    <= 1'b0;
                mem_z[i]    <= 1'b0;
                mem_op[i]   <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= result;
                mem_c[wr_ptr]    <= carry;
                mem_z[wr_ptr]    <= (result == 8'h00);
                mem_op[wr_ptr]   <= select;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new divide-by-zero push takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)
            div0_seen <= 1'b0;
        else if (push && div0_hit)
            div0_seen <= 1'b1;
        else if (clr_div0)
            div0_seen <= 1'b0;
    end

    assign out_data = mem_data[rd_ptr];
    assign out_c    = mem_c[rd_ptr];
    assign out_z    = mem_z[rd_ptr];
    assign out_op   = mem_op[rd_ptr];

`ifdef ALU8_WB_OVF_EN
    logic mem_v [DEPTH];
    logic ovf;

    always_comb begin
        ovf = 1'b0;
        case (select)
            OP_ADD, OP_ADC: ovf = (A[7] == B[7]) && (result[7] != A[7]);
            OP_SUB, OP_SBB: ovf = (A[7] != B[7]) && (result[7] != A[7]);
            default:        ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_v[i] <= 1'b0;
        end else if (push) begin
            mem_v[wr_ptr] <= ovf;
        end
    end

    assign out_v = mem_v[rd_ptr];
`endif

endmodule

// File: tb/tb_alu8_wb.sv
// Directed self-checking bench for alu8_wb: flags, sticky div0, full/empty
// boundaries, sustained push+pop, mid-stream reset and the optional overflow flag.
module tb_alu8_wb;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, cin, bin;
    logic [7:0] A, B, alu_out, out_data;
    logic [3:0] select, out_op;
    logic       out_valid, out_ready, out_c, out_z, div0_seen, clr_div0;
    logic [2:0] count;
`ifdef ALU8_WB_OVF_EN
    logic       out_v;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu8_wb #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .select(select), .cin(cin), .bin(bin), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_c(out_c), .out_z(out_z), .out_op(out_op), .count(count),
        .div0_seen(div0_seen), .clr_div0(clr_div0)
`ifdef ALU8_WB_OVF_EN
        , .out_v(out_v)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input logic ci, input logic bi, input logic [7:0] alu);
        A = a; B = b; select = sel; cin = ci; bin = bi; alu_out = alu;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic c,
                           input logic z, input logic [3:0] op);
        check({tag, "_valid"}, 16'(out_valid), 16'h1);
        check({tag, "_data"}, 16'(out_data), 16'(d));
        check({tag, "_c"}, 16'(out_c), 16'(c));
        check({tag, "_z"}, 16'(out_z), 16'(z));
        check({tag, "_op"}, 16'(out_op), 16'(op));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_div0 = 1'b0;
        A = 8'h00; B = 8'h00; select = 4'h0; cin = 1'b0; bin = 1'b0; alu_out = 8'h00;
        tick();
        tick();
        check("rst_in_ready", 16'(in_ready), 16'h0);
        rst = 1'b0;
        #1;
        check("reset_count", 16'(count), 16'h0);
        check("reset_out_valid", 16'(out_valid), 16'h0);
        check("reset_in_ready", 16'(in_ready), 16'h1);
        check("reset_out_data", 16'(out_data), 16'h0);
        check("reset_out_c", 16'(out_c), 16'h0);
        check("reset_div0", 16'(div0_seen), 16'h0);

        // out_ready while empty must be ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("empty_pop_count", 16'(count), 16'h0);

        push(8'hF0, 8'h20, 4'b0000, 1'b0, 1'b0, 8'h10);
        check("add_count", 16'(count), 16'h1);
        pop_chk("add", 8'h10, 1'b1, 1'b0, 4'b0000);
        check("add_drained", 16'(out_valid), 16'h0);

        push(8'h05, 8'h05, 4'b0101, 1'b0, 1'b1, 8'hFF);
        pop_chk("sbb", 8'hFF, 1'b1, 1'b0, 4'b0101);
        push(8'h05, 8'h05, 4'b0001, 1'b0, 1'b0, 8'h00);
        pop_chk("sub", 8'h00, 1'b0, 1'b1, 4'b0001);

        push(8'h09, 8'h00, 4'b0011, 1'b0, 1'b0, 8'h55);
        check("div0_set", 16'(div0_seen), 16'h1);
        pop_chk("div0", 8'hFF, 1'b1, 1'b0, 4'b0011);
        check("div0_sticky", 16'(div0_seen), 16'h1);
        clr_div0 = 1'b1;
        tick();
        clr_div0 = 1'b0;
        check("div0_clr", 16'(div0_seen), 16'h0);
        clr_div0 = 1'b1;
        push(8'h01, 8'h00, 4'b0011, 1'b0, 1'b0, 8'h00);
        clr_div0 = 1'b0;
        check("div0_set_wins", 16'(div0_seen), 16'h1);
        pop_chk("div0b", 8'hFF, 1'b1, 1'b0, 4'b0011);
        clr_div0 = 1'b1;
        tick();
        clr_div0 = 1'b0;
        // Non-zero divisor must not set the flag
        push(8'h08, 8'h02, 4'b0011, 1'b0, 1'b0, 8'h04);
        check("div_ok_no_div0", 16'(div0_seen), 16'h0);
        pop_chk("div", 8'h04, 1'b0, 1'b0, 4'b0011);

        push(8'h10, 8'h10, 4'b0010, 1'b0, 1'b0, 8'h00);
        push(8'hFF, 8'h00, 4'b0100, 1'b1, 1'b0, 8'h00);
        push(8'hFF, 8'hFF, 4'b0110, 1'b0, 1'b0, 8'hFF);
        push(8'h80, 8'h00, 4'b1110, 1'b0, 1'b0, 8'h01);
        pop_chk("mul_ovf", 8'h00, 1'b1, 1'b1, 4'b0010);
        pop_chk("adc", 8'h00, 1'b1, 1'b1, 4'b0100);
        pop_chk("logic", 8'hFF, 1'b0, 1'b0, 4'b0110);
        pop_chk("shl", 8'h01, 1'b1, 1'b0, 4'b1110);
        push(8'h0F, 8'h11, 4'b0010, 1'b0, 1'b0, 8'hFF);
        push(8'h05, 8'h04, 4'b0101, 1'b0, 1'b1, 8'h00);
        push(8'h00, 8'h01, 4'b1111, 1'b0, 1'b0, 8'h00);
        pop_chk("mul_255", 8'hFF, 1'b0, 1'b0, 4'b0010);
        pop_chk("sbb_eq", 8'h00, 1'b0, 1'b1, 4'b0101);
        pop_chk("shr", 8'h00, 1'b1, 1'b1, 4'b1111);

        for (int i = 0; i < 5; i++)
            push(8'h00, 8'h00, 4'b0111, 1'b0, 1'b0, 8'hA0 + 8'(i));
        check("full_count", 16'(count), 16'h4);
        check("full_in_ready", 16'(in_ready), 16'h0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        alu_out = 8'hEE;
        #1;
        check("full_in_ready_pop", 16'(in_ready), 16'h0);
        check("full_head", 16'(out_data), 16'hA0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("full_pop_count", 16'(count), 16'h3);
        check("after_pop_in_ready", 16'(in_ready), 16'h1);
        pop_chk("fifo1", 8'hA1, 1'b0, 1'b0, 4'b0111);
        pop_chk("fifo2", 8'hA2, 1'b0, 1'b0, 4'b0111);
        pop_chk("fifo3", 8'hA3, 1'b0, 1'b0, 4'b0111);
        check("drain_count", 16'(count), 16'h0);
        check("drain_valid", 16'(out_valid), 16'h0);

        push(8'h00, 8'h00, 4'b1000, 1'b0, 1'b0, 8'h01);
        push(8'h00, 8'h00, 4'b1000, 1'b0, 1'b0, 8'h02);
        for (int i = 0; i < 10; i++) begin
            check("stream_head", 16'(out_data), 16'(i + 1));
            A = 8'h00; B = 8'h00; select = 4'b1000; alu_out = 8'(i + 3);
            in_valid = 1'b1;
            out_ready = 1'b1;
            tick();
            check("stream_count", 16'(count), 16'h2);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("stream_tail", 16'(out_data), 16'd11);
        in_valid = 1'b1;
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("midrst_count", 16'(count), 16'h0);
        check("midrst_valid", 16'(out_valid), 16'h0);
        check("midrst_data", 16'(out_data), 16'h0);

`ifdef ALU8_WB_OVF_EN
        push(8'h7F, 8'h01, 4'b0000, 1'b0, 1'b0, 8'h80);
        check("ovf_add_v", 16'(out_v), 16'h1);
        pop_chk("ovf_add", 8'h80, 1'b0, 1'b0, 4'b0000);
        push(8'h80, 8'h01, 4'b0001, 1'b0, 1'b0, 8'h7F);
        check("ovf_sub_v", 16'(out_v), 16'h1);
        pop_chk("ovf_sub", 8'h7F, 1'b0, 1'b0, 4'b0001);
        push(8'h7F, 8'h01, 4'b0110, 1'b0, 1'b0, 8'h80);
        check("ovf_logic_v", 16'(out_v), 16'h0);
        pop_chk("ovf_logic", 8'h80, 1'b0, 1'b0, 4'b0110);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
